// File: rtl/d_mem_pkg.sv
// Shared types and constants for the d_mem_port load/store responder.
// Holds the FSM state type, the size encodings and the word-index width helper.
// Imported by d_mem_port and d_mem_array.
package d_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic SIZE_BYTE  = 1'b0;
  localparam logic SIZE_DWORD = 1'b1;

  // Width of the word index for a RAM of 'depth' 64-bit words (minimum 1).
  function automatic int idx_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/d_mem_array.sv
// Synchronous single-port DEPTHx64 RAM with per-byte write enables.
// Latency: read data appears one cycle after an enabled read; writes land at the clock edge.
// Backpressure: none; the owner issues at most one read or one write per cycle.
//
// Ports:
//   clock         rising-edge clock
//   en            access enable (read when we=0, write when we=1)
//   we            write enable
//   be[7:0]       byte-lane write mask, bit b covers wdata[8b+7:8b]
//   addr          word index
//   wdata/rdata   write data / registered read data
// Contents are not reset.
module d_mem_array
  import d_mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IW    = idx_width(DEPTH)
) (
  input  logic          clock,
  input  logic          en,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [IW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        // A masked write lets a byte store touch one lane without a read first.
        for (int b = 0; b < 8; b++) begin
          if (be[b]) begin
            mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/d_mem_port.sv
// Data-memory responder: one load/store at a time against an internal RAM with fixed wait states.
// Latency: req to done is WAIT_STATES+2 cycles; busy covers the WAIT_STATES+1 ACCESS cycles.
// Backpressure: req is only sampled in IDLE; requests while busy or done are dropped, not queued.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   req                request strobe (sampled in IDLE only)
//   we, size           1=store/0=load, 0=byte/1=doubleword
//   address, wdata     byte address, store data (byte stores use wdata[7:0])
//   rdata              load result, valid with done and held until the next done
//   busy, done, error  in flight, one-cycle completion, access fault (valid with done)
//
// Build option: define D_MEM_BYTE_EN to enable byte loads/stores; otherwise size is
// ignored, every access is a doubleword and the alignment check always applies.
module d_mem_port
  import d_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic        size,
  input  logic [63:0] address,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int IW = idx_width(DEPTH);

  state_t        state;
  logic [3:0]    cnt;
  logic          we_q;
  logic [IW-1:0] idx_q;
  logic [63:0]   wdata_q;
  logic          err_q;
  logic [63:0]   rdata_q;
  logic          error_q;

  logic          req_oor;
  logic          req_mis;
  logic          req_err;

  logic          ram_en;
  logic          ram_we;
  logic [7:0]    ram_be;
  logic [63:0]   ram_wdata;
  logic [63:0]   ram_rdata;
  logic [63:0]   load_val;
  logic [63:0]   resp_rdata;

`ifdef D_MEM_BYTE_EN
  logic          size_q;
  logic [2:0]    lane_q;
`else
  logic          unused_size;
  assign unused_size = size;
`endif

  // Faults are decided from the live request and carried with it.
  assign req_oor = |address[63:3+IW];
`ifdef D_MEM_BYTE_EN
  assign req_mis = (size == SIZE_DWORD) && (|address[2:0]);
`else
  assign req_mis = |address[2:0];
`endif
  assign req_err = req_oor | req_mis;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 64'd0;
      err_q   <= 1'b0;
      rdata_q <= 64'd0;
      error_q <= 1'b0;
`ifdef D_MEM_BYTE_EN
      size_q  <= SIZE_DWORD;
      lane_q  <= 3'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            idx_q   <= address[3 +: IW];
            wdata_q <= wdata;
            err_q   <= req_err;
`ifdef D_MEM_BYTE_EN
            size_q  <= size;
            lane_q  <= address[2:0];
`endif
            cnt     <= 4'(WAIT_STATES);
            state   <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // The zero-count cycle is still an ACCESS cycle, so ACCESS spans WAIT_STATES+1.
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          rdata_q <= resp_rdata;
          error_q <= err_q;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The read is issued on the last ACCESS cycle so the registered RAM output is
  // ready in RESP; the write is committed in RESP so an abort in ACCESS never writes.
  assign ram_we = (state == ST_RESP) && we_q && !err_q;
  assign ram_en = ram_we || ((state == ST_ACCESS) && (cnt == 4'd0) && !we_q);

`ifdef D_MEM_BYTE_EN
  assign ram_be    = (size_q == SIZE_BYTE) ? (8'b1 << lane_q) : 8'hFF;
  assign ram_wdata = (size_q == SIZE_BYTE) ? {8{wdata_q[7:0]}} : wdata_q;
  assign load_val  = (size_q == SIZE_BYTE) ? {56'd0, ram_rdata[{lane_q, 3'b000} +: 8]}
                                           : ram_rdata;
`else
  assign ram_be    = 8'hFF;
  assign ram_wdata = wdata_q;
  assign load_val  = ram_rdata;
`endif

  // A good store leaves the previous load result in place.
  assign resp_rdata = err_q ? 64'd0 : (we_q ? rdata_q : load_val);

  d_mem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clock (clock),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (idx_q),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Outputs present the fresh result in the done cycle and the held copy elsewhere.
  assign busy  = (state == ST_ACCESS);
  assign done  = (state == ST_RESP);
  assign rdata = done ? resp_rdata : rdata_q;
  assign error = done ? err_q : error_q;

endmodule

// File: tb/tb_d_mem_port.sv
// Self-checking bench for d_mem_port: directed cases plus randomized traffic checked
// against a word-array reference model built from the access rules.
// Handles both builds (D_MEM_BYTE_EN defined or not).
module tb_d_mem_port;
  localparam int DEPTH = 256;
  localparam int WS    = 2;
  localparam int IW    = $clog2(DEPTH);
`ifdef D_MEM_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        size = 1'b1;
  logic [63:0] address = 64'd0;
  logic [63:0] wdata = 64'd0;
  logic [63:0] rdata;
  logic        busy;
  logic        done;
  logic        error;

  d_mem_port #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .we      (we),
    .size    (size),
    .address (address),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clock = ~clock;

  logic [63:0] mdl [DEPTH];
  logic [63:0] last_rd = 64'd0;
  logic        last_err = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Reference: word array, access rules applied directly to the byte address.
  task automatic model_access(input logic w, input logic s, input logic [63:0] a,
                              input logic [63:0] d, output logic e, output logic [63:0] r);
    bit dword;
    bit oor;
    bit mis;
    int idx;
    int lane;
    dword = !BYTE_EN || s;
    oor   = (a >> (3 + IW)) != 64'd0;
    mis   = dword && (a[2:0] != 3'd0);
    e     = oor || mis;
    lane  = int'(a[2:0]);
    idx   = int'(a[3 +: IW]);
    if (e) begin
      r = 64'd0;
    end else if (w) begin
      if (dword) mdl[idx] = d;
      else       mdl[idx][lane*8 +: 8] = d[7:0];
      r = last_rd;
    end else begin
      r = dword ? mdl[idx] : {56'd0, mdl[idx][lane*8 +: 8]};
    end
    last_rd  = r;
    last_err = e;
  endtask

  // Issues one request from IDLE and returns at the negedge of the following IDLE cycle.
  task automatic do_req(input logic w, input logic s, input logic [63:0] a,
                        input logic [63:0] d, input bit mid_pulse, output logic [63:0] got);
    logic        e_err;
    logic [63:0] e_rd;
    int  cyc;
    bit  busy_ok;
    bit  seen;
    model_access(w, s, a, d, e_err, e_rd);
    we = w; size = s; address = a; wdata = d; req = 1'b1;
    @(posedge clock);
    #1 req = 1'b0;
    cyc = 0; busy_ok = 1'b1; seen = 1'b0; got = 64'd0;
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (mid_pulse && cyc == 1) begin
        we = 1'b1; size = 1'b1; address = 64'd0; wdata = ~mdl[0]; req = 1'b1;
      end
      if (mid_pulse && cyc == 2) req = 1'b0;
      if (done) begin
        seen = 1'b1;
        got  = rdata;
        chk_val("latency", 64'(cyc), 64'(WS + 2));
        chk_val("busy_at_done", 64'(busy), 64'd0);
        chk_val("error", 64'(error), 64'(e_err));
        chk_val("rdata", rdata, e_rd);
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    req = 1'b0;
    chk_val("done_seen", 64'(seen), 64'd1);
    chk_val("busy_window", 64'(busy_ok), 64'd1);
    @(negedge clock);
    chk_val("done_pulse_len", 64'(done), 64'd0);
    chk_val("rdata_hold", rdata, last_rd);
    chk_val("error_hold", 64'(error), 64'(last_err));
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: a = 64'($urandom_range(0, DEPTH - 1)) << 3;
      6, 7:    a = (64'($urandom_range(0, DEPTH - 1)) << 3) | 64'($urandom_range(0, 7));
      8:       a = {$urandom, $urandom} | (64'd1 << (3 + IW + $urandom_range(0, 60 - IW)));
      default: a = 64'(DEPTH * 8) + 64'($urandom_range(0, 7));
    endcase
    return a;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] got;
    logic [63:0] w0;
    logic [63:0] pre80;
    logic        e_dummy;
    logic [63:0] r_dummy;
    int t1, t2, cyc, ndone, extra;

    repeat (3) @(negedge clock);
    chk_val("reset_rdata", rdata, 64'd0);
    chk_val("reset_busy", 64'(busy), 64'd0);
    chk_val("reset_done", 64'(done), 64'd0);
    chk_val("reset_error", 64'(error), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Give every word a known value so all later loads are predictable.
    for (int i = 0; i < DEPTH; i++) begin
      do_req(1'b1, 1'b1, 64'(i) << 3, {$urandom, $urandom}, 1'b0, got);
    end

    // Doubleword store then load.
    do_req(1'b1, 1'b1, 64'h40, 64'h0123456789ABCDEF, 1'b0, got);
    do_req(1'b0, 1'b1, 64'h40, 64'd0, 1'b0, got);
    chk_val("dw_load_0x40", got, 64'h0123456789ABCDEF);

    // Byte store / load of lane 3.
    do_req(1'b1, 1'b0, 64'h43, 64'hFF, 1'b0, got);
    do_req(1'b0, 1'b1, 64'h40, 64'd0, 1'b0, got);
`ifdef D_MEM_BYTE_EN
    chk_val("byte_store_merge", got, 64'h01234567FFABCDEF);
    do_req(1'b0, 1'b0, 64'h43, 64'd0, 1'b0, got);
    chk_val("byte_load_0x43", got, 64'h00000000000000FF);
`else
    chk_val("byte_store_rejected", got, 64'h0123456789ABCDEF);
`endif

    // Misaligned doubleword load.
    do_req(1'b0, 1'b1, 64'h41, 64'd0, 1'b0, got);
    chk_val("misalign_rdata", got, 64'd0);
    chk_val("misalign_error", 64'(error), 64'd1);
    do_req(1'b0, 1'b1, 64'h40, 64'd0, 1'b0, got);
    chk_val("misalign_mem", got, mdl[8]);

    // Out-of-range store must not alias onto word 0.
    w0 = mdl[0];
    do_req(1'b1, 1'b1, 64'(DEPTH * 8), 64'hDEADBEEFCAFEF00D, 1'b0, got);
    chk_val("oor_error", 64'(error), 64'd1);
    do_req(1'b0, 1'b1, 64'h0, 64'd0, 1'b0, got);
    chk_val("oor_word0", got, w0);

    // Request pulsed while busy (a store to word 0) must be dropped.
    do_req(1'b0, 1'b1, 64'h40, 64'd0, 1'b1, got);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done || busy) extra++;
    end
    chk_val("ignored_no_access", 64'(extra), 64'd0);
    do_req(1'b0, 1'b1, 64'h0, 64'd0, 1'b0, got);
    chk_val("ignored_word0", got, w0);

    // req held through done: next access starts from the following IDLE cycle.
    model_access(1'b0, 1'b1, 64'h80, 64'd0, e_dummy, r_dummy);
    we = 1'b0; size = 1'b1; address = 64'h80; req = 1'b1;
    cyc = 0; ndone = 0; t1 = 0; t2 = 0;
    while (ndone < 2 && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (done) begin
        ndone++;
        if (ndone == 1) t1 = cyc;
        else begin
          t2 = cyc;
          req = 1'b0;
          chk_val("b2b_rdata", rdata, r_dummy);
        end
      end
    end
    req = 1'b0;
    chk_val("b2b_count", 64'(ndone), 64'd2);
    chk_val("b2b_gap", 64'(t2 - t1), 64'(WS + 3));
    @(negedge clock);

    // Reset in the middle of a store to 0x80.
    pre80 = mdl[16];
    do_req(1'b0, 1'b1, 64'h40, 64'd0, 1'b0, got);
    we = 1'b1; size = 1'b1; address = 64'h80; wdata = ~pre80; req = 1'b1;
    @(posedge clock);
    #1 req = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_val("rst_mid_rdata", rdata, 64'd0);
    chk_val("rst_mid_busy", 64'(busy), 64'd0);
    chk_val("rst_mid_done", 64'(done), 64'd0);
    chk_val("rst_mid_error", 64'(error), 64'd0);
    last_rd = 64'd0; last_err = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    do_req(1'b0, 1'b1, 64'h80, 64'd0, 1'b0, got);
    chk_val("rst_mid_mem", got, pre80);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
             {$urandom, $urandom}, 1'b0, got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/d_mem_port.md
# d_mem_port

Data-memory responder for the load/store path. Accepts one memory request at a time from the control unit: the request is built from the D-format control word, with the ALU result as address and the register-file B bus as store data. It performs the access against an internal word-organised RAM with a fixed number of wait states, and returns load data with a one-cycle completion pulse. It sits between the datapath's data bus and the RAM, replacing the single-cycle `ram_en`/`ram_w` assumption with a handshake.

## Interface
- `DEPTH`, 256: number of 64-bit words in the RAM; power of two.
- `WAIT_STATES`, 2: cycles spent in ACCESS before completion; legal range 0–15.
- `clock` input 1: single clock, rising-edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 1: request strobe, sampled only in IDLE.
- `we` input 1: 1 = store, 0 = load.
- `size` input 1: 0 = byte, 1 = doubleword.
- `address` input 64: byte address.
- `wdata` input 64: store data; byte stores use `wdata[7:0]`.
- `rdata` output 64: load result, zero-extended for byte loads.
- `busy` output 1: high while a request is in flight.
- `done` output 1: one-cycle completion pulse.
- `error` output 1: valid with `done`; misaligned or out-of-range access.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE with `req`=1:
  - Latch `we`, `size`, `address`, `wdata`.
  - Load the wait counter with `WAIT_STATES`.
  - Go to ACCESS.
- ACCESS:
  - Decrement the counter each cycle.
  - At zero, go to RESP.
  - With `WAIT_STATES`=0, ACCESS lasts exactly one cycle.
- RESP:
  - Assert `done` for one cycle.
  - Commit a store, or drive `rdata` for a load.
  - Return to IDLE.
- Word index is `address[3+log2(DEPTH)-1:3]`; byte lane is `address[2:0]`.
- Error conditions:
  - Doubleword access with `address[2:0]` not equal to 0.
  - Any `address` bits above the word index that are nonzero.
- On error: no RAM write; `rdata` is forced to 0; `error`=1 with `done`.
- Byte store: read-modify-write of one lane. The other seven bytes are unchanged.
- Byte load: `rdata` = {56'b0, selected byte}.
- Reset values:
  - `rdata`=0, `busy`=0, `done`=0, `error`=0; state IDLE.
  - RAM contents are not reset.

## Timing
- Request at edge N gives `busy`=1 from N+1 through N+1+`WAIT_STATES` inclusive.
- `done` is high in cycle N+2+`WAIT_STATES`; `busy` is 0 in that cycle.
- Load latency, `req` to `done`, is `WAIT_STATES`+2 cycles.
- `rdata` and `error` hold their last values until the next `done`.
- A store becomes visible to a load requested on or after its `done` cycle.
- `req` while `busy` or `done` is ignored and not queued.
- Back-to-back: a `req` held high through the `done` cycle is accepted on the next IDLE cycle.
- Reset asserted mid-ACCESS:
  - Aborts immediately; the pending store is never committed.
  - `done` is not pulsed.
  - The RAM keeps its prior contents.

## Configuration
- `D_MEM_BYTE_EN` defined:
  - Byte loads and stores are supported as described.
  - `size`=0 disables the alignment check.
- `D_MEM_BYTE_EN` undefined:
  - `size` is ignored and every access is doubleword.
  - The alignment check always applies.
  - No read-modify-write lane logic is built.

## Structure
- Package `d_mem_pkg`:
  - FSM state enum.
  - `SIZE_BYTE`=1'b0 and `SIZE_DWORD`=1'b1 constants.
  - Helper for word-index width from `DEPTH`.
- One sub-module, `d_mem_array`:
  - Synchronous single-port `DEPTH`x64 RAM.
  - Write enable plus 8-bit byte-enable mask.
  - Registered read.
  - This lets the byte store become a single masked write rather than explicit read-modify-write.

## Test plan
- Doubleword store, then load:
  - Store 0x0123456789ABCDEF at address 0x40, then load 0x40.
  - Expect `rdata`=0x0123456789ABCDEF and `error`=0.
  - Expect `done` exactly `WAIT_STATES`+2 cycles after each `req`.
- Byte store (`D_MEM_BYTE_EN`):
  - Start from 0x0123456789ABCDEF at 0x40; byte-store 0xFF at 0x43.
  - A doubleword load of 0x40 returns 0x01234567FFABCDEF.
  - A byte load of 0x43 returns 0x00000000000000FF.
- Misaligned doubleword:
  - Load 0x41.
  - Expect `error`=1 and `rdata`=0.
  - A following load of 0x40 shows the memory unchanged.
- Out of range:
  - Store to address `DEPTH`*8.
  - Expect `error`=1 and no word modified; check word 0 is unchanged.
- Ignored request:
  - Pulse `req` during `busy`.
  - Expect exactly one `done`; the second request produces no access.
- Reset mid-operation:
  - Assert `reset_n`=0 in the middle of a store to 0x80.
  - All outputs read 0 immediately.
  - A later load of 0x80 returns the pre-store value.
